// File: rtl/approx_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : approx_error_monitor
// Description : Recomputes the exact sum for each {s_pi, s_po} sample from an
//               approximate adder and accumulates error metrics over a run.
//               Optional per-bit flip counters: define APPROX_ERR_BITFLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_error_monitor #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 5,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_pi,
  input  logic [OUT_W-1:0] s_po,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] err_sum,
  output logic [CNT_W-1:0] err_max
`ifdef APPROX_ERR_BITFLIP_EN
  ,
  output logic [OUT_W*CNT_W-1:0] bit_err
`endif
);

  localparam int HALF = IN_W / 2;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state, w_next;
  logic [CNT_W-1:0] r_target, r_xfer_cnt, w_xfer_next;
  logic             r_s1_valid, r_s1_mis;
  logic [OUT_W-1:0] r_s1_diff;
  logic [CNT_W-1:0] r_sample_cnt, r_err_cnt, r_err_max;
  logic [ACC_W-1:0] r_err_sum;

  logic [OUT_W-1:0] w_exact, w_diff;
  logic [ACC_W:0]   w_sum_ext;
  logic [CNT_W-1:0] w_diff_ext;
  logic             w_xfer, w_start_acc;

  assign w_exact = {{(OUT_W-HALF){1'b0}}, s_pi[HALF-1:0]}
                 + {{(OUT_W-HALF){1'b0}}, s_pi[IN_W-1:HALF]};
  // Magnitude of the signed difference, taken without a wider intermediate.
  assign w_diff      = (s_po >= w_exact) ? (s_po - w_exact) : (w_exact - s_po);
  assign w_xfer      = s_valid && (r_state == c_st_run);
  assign w_start_acc = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_xfer_next = r_xfer_cnt + c_cnt_one;
  assign w_sum_ext   = {1'b0, r_err_sum} + {{(ACC_W+1-OUT_W){1'b0}}, r_s1_diff};
  assign w_diff_ext  = {{(CNT_W-OUT_W){1'b0}}, r_s1_diff};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle, c_st_done: begin
        if (start) w_next = (num_samples == '0) ? c_st_done : c_st_run;
      end
      c_st_run: begin
        if (w_xfer && (w_xfer_next == r_target)) w_next = c_st_drain;
      end
      c_st_drain: begin
        if (!r_s1_valid) w_next = c_st_done;
      end
      default: w_next = c_st_idle;
    endcase
  end

  always_comb begin
    s_ready = (r_state == c_st_run);
    busy    = (r_state == c_st_run) || (r_state == c_st_drain);
    done    = (r_state == c_st_done);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_mis     <= 1'b0;
      r_s1_diff    <= '0;
      r_target     <= '0;
      r_xfer_cnt   <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_err_sum    <= '0;
      r_err_max    <= '0;
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_diff <= w_diff;
        r_s1_mis  <= (s_po != w_exact);
      end
      if (w_start_acc) begin
        r_target     <= num_samples;
        r_xfer_cnt   <= '0;
        r_sample_cnt <= '0;
        r_err_cnt    <= '0;
        r_err_sum    <= '0;
        r_err_max    <= '0;
      end else begin
        if (w_xfer) r_xfer_cnt <= w_xfer_next;
        if (r_s1_valid) begin
          if (r_sample_cnt != '1)          r_sample_cnt <= r_sample_cnt + c_cnt_one;
          if (r_s1_mis && r_err_cnt != '1) r_err_cnt    <= r_err_cnt + c_cnt_one;
          r_err_sum <= w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
          if (w_diff_ext > r_err_max)      r_err_max    <= w_diff_ext;
        end
      end
    end
  end

  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign err_sum    = r_err_sum;
  assign err_max    = r_err_max;

`ifdef APPROX_ERR_BITFLIP_EN
  logic [OUT_W-1:0] r_s1_flip;
  logic [CNT_W-1:0] r_bit_err [OUT_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_flip <= '0;
      for (int i = 0; i < OUT_W; i++) r_bit_err[i] <= '0;
    end else begin
      if (w_xfer) r_s1_flip <= s_po ^ w_exact;
      for (int i = 0; i < OUT_W; i++) begin
        if (w_start_acc)
          r_bit_err[i] <= '0;
        else if (r_s1_valid && r_s1_flip[i] && (r_bit_err[i] != '1))
          r_bit_err[i] <= r_bit_err[i] + c_cnt_one;
      end
    end
  end

  for (genvar g = 0; g < OUT_W; g++) begin : g_bit_err
    assign bit_err[g*CNT_W +: CNT_W] = r_bit_err[g];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_error_monitor
// Description : Directed self-checking bench for approx_error_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n, start, s_valid;
  logic [15:0] num_samples;
  logic [7:0]  s_pi;
  logic [4:0]  s_po;
  logic        s_ready, busy, done;
  logic [15:0] sample_cnt, err_cnt, err_max;
  logic [23:0] err_sum;
`ifdef APPROX_ERR_BITFLIP_EN
  logic [79:0] bit_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int xfers    = 0;
  int xbase;
  logic [7:0] p;

  always #5 clk = ~clk;

  always @(posedge clk) if (s_valid && s_ready) xfers <= xfers + 1;

  approx_error_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .s_valid(s_valid), .s_ready(s_ready), .s_pi(s_pi), .s_po(s_po),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .err_sum(err_sum), .err_max(err_max)
`ifdef APPROX_ERR_BITFLIP_EN
    , .bit_err(bit_err)
`endif
  );

  function automatic logic [4:0] ex(input logic [7:0] v);
    return {1'b0, v[3:0]} + {1'b0, v[7:4]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] pi, input logic [4:0] po);
    int g = 0;
    s_pi = pi;
    s_po = po;
    s_valid = 1'b1;
    while (!s_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("send_timeout", 32'(g), 0);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!done && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_done"}, 32'(done), 1);
  endtask

  task automatic chk_res(input string tag, input int sc, input int ec, input int es, input int em);
    chk({tag, "_scnt"}, 32'(sample_cnt), sc);
    chk({tag, "_ecnt"}, 32'(err_cnt), ec);
    chk({tag, "_esum"}, 32'(err_sum), es);
    chk({tag, "_emax"}, 32'(err_max), em);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
    num_samples = '0; s_pi = '0; s_po = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk_res("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact model, 16 back-to-back samples; done two cycles after last transfer
    do_start(16);
    chk("s1_ready", 32'(s_ready), 1);
    for (int i = 0; i < 16; i++) begin
      p = 8'($urandom_range(0, 255));
      send(p, ex(p));
    end
    s_valid = 1'b0;
    chk("s1_drain_ready", 32'(s_ready), 0);
    chk("s1_drain_busy",  32'(busy), 1);
    chk("s1_done_t1",     32'(done), 0);
    @(negedge clk);
    chk("s1_done_t2",     32'(done), 0);
    @(negedge clk);
    chk("s1_done_t3",     32'(done), 1);
    chk_res("s1", 16, 0, 0, 0);

    // One sample: A=4 B=9 exact=13, po=15
    do_start(1);
    chk("s2_done_clr", 32'(done), 0);
    chk("s2_busy",     32'(busy), 1);
    send(8'b10010100, 5'b01111);
    s_valid = 1'b0;
    wait_done("s2");
    chk_res("s2", 1, 1, 2, 2);

    // Three samples with diffs 2, 0, 30
    do_start(3);
    send(8'b11011001, 5'b10100);
    send(8'b00010001, 5'b00010);
    send(8'b11111111, 5'b00000);
    s_valid = 1'b0;
    wait_done("s3");
    chk_res("s3", 3, 2, 32, 30);
`ifdef APPROX_ERR_BITFLIP_EN
    chk("s3_bit0", 32'(bit_err[0*16 +: 16]), 0);
    chk("s3_bit1", 32'(bit_err[1*16 +: 16]), 2);
    chk("s3_bit2", 32'(bit_err[2*16 +: 16]), 1);
    chk("s3_bit3", 32'(bit_err[3*16 +: 16]), 1);
    chk("s3_bit4", 32'(bit_err[4*16 +: 16]), 1);
`endif

    // Zero-length run with s_valid held high: no transfer may happen
    xbase = xfers;
    s_valid = 1'b1;
    s_pi = 8'hFF;
    s_po = 5'd0;
    do_start(0);
    chk("s4_done",  32'(done), 1);
    chk("s4_busy",  32'(busy), 0);
    chk("s4_ready", 32'(s_ready), 0);
    repeat (3) @(negedge clk);
    chk("s4_ready_late", 32'(s_ready), 0);
    s_valid = 1'b0;
    chk("s4_xfers", 32'(xfers - xbase), 0);
    chk_res("s4", 0, 0, 0, 0);

    // s_valid toggling, each sample off by one; mid-run start must be ignored
    xbase = xfers;
    do_start(4);
    for (int i = 0; i < 14; i++) begin
      s_valid = (i % 2 == 0);
      s_pi = 8'(i * 37 + 5);
      s_po = ex(s_pi) ^ 5'd1;
      start = (i == 3);
      num_samples = (i == 3) ? 16'd9 : 16'd4;
      @(negedge clk);
    end
    start = 1'b0;
    s_valid = 1'b0;
    wait_done("s5");
    chk("s5_xfers", 32'(xfers - xbase), 4);
    chk_res("s5", 4, 4, 4, 1);

    // Reset in the middle of a run discards it
    do_start(10);
    send(8'h11, 5'd3);
    send(8'h11, 5'd3);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("s6_busy",  32'(busy), 0);
    chk("s6_done",  32'(done), 0);
    chk("s6_ready", 32'(s_ready), 0);
    chk_res("s6", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("s6_done_after", 32'(done), 0);
    chk("s6_scnt_after", 32'(sample_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
